// File: rtl/step_scheduler_if.sv
// Control/pattern-write inputs and playback outputs of step_scheduler, bundled with
// master (stimulus side) and slave (scheduler side) modports.
interface step_scheduler_if #(
    parameter int STEPS  = 16,
    parameter int VOICES = 10
);
    localparam int SW = $clog2(STEPS);

    logic              Start;
    logic              Stop;
    logic [9:0]        BPM;
    logic [6:0]        Loops;
    logic              PatWe;
    logic [SW-1:0]     PatAddr;
    logic [VOICES-1:0] PatData;

    logic              Busy;
    logic [SW-1:0]     Step;
    logic              StepStrobe;
    logic              Trigger;
    logic [VOICES-1:0] Voice;
    logic [6:0]        LoopCount;
    logic              Done;

    modport master (
        output Start, Stop, BPM, Loops, PatWe, PatAddr, PatData,
        input  Busy, Step, StepStrobe, Trigger, Voice, LoopCount, Done
    );

    modport slave (
        input  Start, Stop, BPM, Loops, PatWe, PatAddr, PatData,
        output Busy, Step, StepStrobe, Trigger, Voice, LoopCount, Done
    );
endinterface

// File: rtl/step_scheduler.sv
// Pattern playback sequencer with an exact phase-accumulator tempo generator.
// Optional STEP_SCHEDULER_LIVE_BPM_EN: re-sample BPM at every step boundary.
module step_scheduler #(
    parameter int CLK_HZ = 50_000_000,
    parameter int STEPS  = 16,
    parameter int VOICES = 10
) (
    input  logic             CLOCK_50,
    input  logic             nReset,
    step_scheduler_if.slave  bus
);
    localparam int SW = $clog2(STEPS);
    // Accumulator wraps at 60*CLK_HZ; adding BPM per cycle yields BPM boundaries per minute.
    localparam logic [31:0] LIMIT = 32'(64'd60 * 64'(CLK_HZ));

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state;
    logic [VOICES-1:0] pattern [STEPS];
    logic [31:0]       acc;
    logic [9:0]        bpm_l;
    logic [6:0]        loops_l;

    logic [31:0]       sum;
    logic              boundary;
    logic              last_step;
    logic [SW-1:0]     next_step;
    logic [6:0]        loop_next;

    function automatic logic [9:0] clamp_bpm(input logic [9:0] b);
        if (b < 10'd30)  return 10'd30;
        if (b > 10'd300) return 10'd300;
        return b;
    endfunction

    assign sum       = acc + 32'(bpm_l);
    assign boundary  = (sum >= LIMIT);
    assign last_step = (bus.Step == SW'(STEPS - 1));
    assign next_step = last_step ? '0 : bus.Step + SW'(1);
    assign loop_next = bus.LoopCount + 7'd1;

    always_ff @(posedge CLOCK_50) begin
        if (!nReset) begin
            state          <= IDLE;
            acc            <= '0;
            bpm_l          <= 10'd30;
            loops_l        <= '0;
            bus.Busy       <= 1'b0;
            bus.Step       <= '0;
            bus.StepStrobe <= 1'b0;
            bus.Trigger    <= 1'b0;
            bus.Voice      <= '0;
            bus.LoopCount  <= '0;
            bus.Done       <= 1'b0;
            for (int i = 0; i < STEPS; i++) pattern[i] <= '0;
        end else begin
            bus.StepStrobe <= 1'b0;
            bus.Trigger    <= 1'b0;
            bus.Done       <= 1'b0;

            if (bus.PatWe) pattern[bus.PatAddr] <= bus.PatData;

            if (bus.Stop) begin
                // Abort: Step/Voice/LoopCount keep their last values.
                state    <= IDLE;
                bus.Busy <= 1'b0;
            end else if (bus.Start) begin
                state          <= PLAY;
                bus.Busy       <= 1'b1;
                bpm_l          <= clamp_bpm(bus.BPM);
                loops_l        <= bus.Loops;
                acc            <= '0;
                bus.LoopCount  <= '0;
                bus.Step       <= '0;
                bus.StepStrobe <= 1'b1;
                bus.Voice      <= pattern[0];
                bus.Trigger    <= |pattern[0];
            end else if (state == PLAY) begin
                if (boundary) begin
                    acc <= sum - LIMIT;
`ifdef STEP_SCHEDULER_LIVE_BPM_EN
                    bpm_l <= clamp_bpm(bus.BPM);
`endif
                    if (last_step) bus.LoopCount <= loop_next;
                    if (last_step && loops_l != 7'd0 && loop_next == loops_l) begin
                        state    <= IDLE;
                        bus.Busy <= 1'b0;
                        bus.Done <= 1'b1;
                    end else begin
                        bus.Step       <= next_step;
                        bus.StepStrobe <= 1'b1;
                        bus.Voice      <= pattern[next_step];
                        bus.Trigger    <= |pattern[next_step];
                    end
                end else begin
                    acc <= sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler at CLK_HZ=100 (LIMIT=6000), STEPS=16.
module tb_step_scheduler;
    localparam int CLK_HZ = 100;
    localparam int STEPS  = 16;
    localparam int VOICES = 10;
    localparam int LIMIT  = 6000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    step_scheduler_if #(.STEPS(STEPS), .VOICES(VOICES)) bus();

    step_scheduler #(.CLK_HZ(CLK_HZ), .STEPS(STEPS), .VOICES(VOICES)) dut (
        .CLOCK_50(clk),
        .nReset  (rst_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  step;
        logic [9:0]  voice;
        logic        trig;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [9:0] pat [STEPS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pat(input int a, input int d);
        bus.PatAddr = 4'(a);
        bus.PatData = 10'(d);
        bus.PatWe   = 1'b1;
        tick();
        bus.PatWe   = 1'b0;
        pat[a]      = 10'(d);
    endtask

    // Start sampled in relative cycle 0; returns in cycle 1.
    task automatic start(input int bpm, input int loops);
        bus.BPM   = 10'(bpm);
        bus.Loops = 7'(loops);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic stop();
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
        tick();
    endtask

    function automatic ev_t mk(input int cyc, input int k);
        ev_t e;
        e.cyc   = 32'(cyc);
        e.step  = 4'(k % STEPS);
        e.voice = pat[k % STEPS];
        e.trig  = (pat[k % STEPS] != 10'd0);
        return e;
    endfunction

    task automatic test_reset();
        logic [24:0] outs;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        outs = {bus.Busy, bus.Step, bus.StepStrobe, bus.Trigger, bus.Voice, bus.LoopCount, bus.Done};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", outs);
        end
    endtask

    task automatic test_basic();
        ev_t got, e;
        int rel, done_at;
        for (int k = 0; k < STEPS; k++) write_pat(k, k);
        for (int k = 0; k < STEPS; k++) exp_q.push_back(mk(1 + 50 * k, k));
        start(120, 1);
        rel = 1;
        done_at = -1;
        while (rel <= 830) begin
            if (bus.StepStrobe) begin
                got = {32'(rel), bus.Step, bus.Voice, bus.Trigger};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL basic_strobe: got cyc=%0d step=%0d voice=%0d trig=%0d, want cyc=%0d step=%0d voice=%0d trig=%0d",
                             got.cyc, got.step, got.voice, got.trig, e.cyc, e.step, e.voice, e.trig);
                end
            end
            if (rel == 800) begin
                checks++;
                if (bus.Busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_busy_800: got %b, want 1", bus.Busy);
                end
            end
            if (bus.Done === 1'b1 && done_at < 0) begin
                done_at = rel;
                checks++;
                if (bus.LoopCount !== 7'd1 || bus.Busy !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_done_state: got loops=%0d busy=%b, want loops=1 busy=0", bus.LoopCount, bus.Busy);
                end
            end
            tick();
            rel++;
        end
        checks++;
        if (done_at != 801) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d, want 801", done_at);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: got %0d strobes left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_nondiv();
        ev_t got, e;
        int rel, n, prev, first;
        for (int k = 0; k <= 70; k++) exp_q.push_back(mk(1 + (LIMIT * k + 69) / 70, k));
        start(70, 0);
        rel = 1; n = 0; prev = 0; first = 0;
        while (exp_q.size() > 0 && rel < 6200) begin
            if (bus.StepStrobe) begin
                got = {32'(rel), bus.Step, bus.Voice, bus.Trigger};
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL nondiv_strobe: got cyc=%0d step=%0d voice=%0d, want cyc=%0d step=%0d voice=%0d",
                             got.cyc, got.step, got.voice, e.cyc, e.step, e.voice);
                end
                if (n == 0) first = rel;
                else begin
                    checks++;
                    if (rel - prev != 85 && rel - prev != 86) begin
                        errors++;
                        $display("FAIL nondiv_spacing: got %0d, want 85 or 86", rel - prev);
                    end
                end
                if (n == 70) begin
                    checks++;
                    if (rel - first != LIMIT) begin
                        errors++;
                        $display("FAIL nondiv_70th: got %0d, want %0d", rel - first, LIMIT);
                    end
                end
                prev = rel;
                n++;
            end
            tick();
            rel++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL nondiv_timeout: got %0d strobes left, want 0", exp_q.size());
            exp_q.delete();
        end
        stop();
    endtask

    task automatic test_clamp();
        ev_t got, e;
        int rel, sp;
        for (int c = 0; c < 2; c++) begin
            sp = (c == 0) ? 200 : 20;
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(1 + sp * k, k));
            start((c == 0) ? 0 : 1000, 0);
            rel = 1;
            while (exp_q.size() > 0 && rel < 4 * sp + 10) begin
                if (bus.StepStrobe) begin
                    got = {32'(rel), bus.Step, bus.Voice, bus.Trigger};
                    e = exp_q.pop_front();
                    checks++;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL clamp_strobe[%0d]: got cyc=%0d step=%0d, want cyc=%0d step=%0d",
                                 c, got.cyc, got.step, e.cyc, e.step);
                    end
                end
                tick();
                rel++;
            end
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL clamp_timeout[%0d]: got %0d strobes left, want 0", c, exp_q.size());
                exp_q.delete();
            end
            stop();
        end
    endtask

    task automatic test_infinite_restart_stop();
        int n, pass, budget;
        logic [3:0] held;
        start(1000, 0);
        n = 0; pass = 0; budget = 0;
        while (pass < 130 && budget < 130 * 16 * 20 + 200) begin
            if (bus.StepStrobe) begin
                if (n > 0 && n % 16 == 0) begin
                    pass = n / 16;
                    checks++;
                    if (bus.LoopCount !== 7'(pass) || bus.Step !== 4'd0 || bus.Busy !== 1'b1) begin
                        errors++;
                        $display("FAIL inf_wrap: got loops=%0d step=%0d busy=%b, want loops=%0d step=0 busy=1",
                                 bus.LoopCount, bus.Step, bus.Busy, 7'(pass));
                    end
                end
                n++;
            end
            if (bus.Done === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL inf_done: got Done=1 at strobe %0d, want 0", n);
            end
            tick();
            budget++;
        end
        checks++;
        if (pass != 130) begin
            errors++;
            $display("FAIL inf_timeout: got pass %0d, want 130", pass);
        end
        budget = 0;
        while (!(bus.StepStrobe && bus.Step == 4'd5) && budget < 200) begin
            tick();
            budget++;
        end
        bus.BPM = 10'd1000;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        checks++;
        if (bus.StepStrobe !== 1'b1 || bus.Step !== 4'd0 || bus.LoopCount !== 7'd0 || bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: got strobe=%b step=%0d loops=%0d busy=%b, want 1 0 0 1",
                     bus.StepStrobe, bus.Step, bus.LoopCount, bus.Busy);
        end
        repeat (45) tick();
        held = bus.Step;
        bus.Stop = 1'b1;
        bus.Start = 1'b1;
        tick();
        bus.Stop = 1'b0;
        bus.Start = 1'b0;
        checks++;
        if (bus.Busy !== 1'b0 || bus.StepStrobe !== 1'b0 || bus.Step !== 4'd2) begin
            errors++;
            $display("FAIL stop_start: got busy=%b strobe=%b step=%0d, want 0 0 2", bus.Busy, bus.StepStrobe, bus.Step);
        end
        for (int i = 0; i < 60; i++) begin
            if (bus.StepStrobe || bus.Done || bus.Step !== held) begin
                checks++;
                errors++;
                $display("FAIL stop_idle: got strobe=%b done=%b step=%0d, want 0 0 %0d", bus.StepStrobe, bus.Done, bus.Step, held);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_play();
        ev_t got, e;
        int rel, budget;
        logic [24:0] outs;
        start(120, 0);
        budget = 0;
        while (!(bus.StepStrobe && bus.Step == 4'd7) && budget < 500) begin
            tick();
            budget++;
        end
        checks++;
        if (bus.Step !== 4'd7) begin
            errors++;
            $display("FAIL rstmid_reach7: got step %0d, want 7", bus.Step);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        outs = {bus.Busy, bus.Step, bus.StepStrobe, bus.Trigger, bus.Voice, bus.LoopCount, bus.Done};
        checks++;
        if (outs !== 25'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h, want 0", outs);
        end
        for (int k = 0; k < STEPS; k++) pat[k] = 10'd0;
        for (int k = 0; k < STEPS; k++) exp_q.push_back(mk(1 + 50 * k, k));
        start(120, 1);
        rel = 1;
        while (rel < 820) begin
            if (bus.StepStrobe || bus.Trigger) begin
                got = {32'(rel), bus.Step, bus.Voice, bus.Trigger};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL rstmid_strobe: got cyc=%0d step=%0d voice=%0d trig=%0d, want cyc=%0d step=%0d voice=%0d trig=%0d",
                             got.cyc, got.step, got.voice, got.trig, e.cyc, e.step, e.voice, e.trig);
                end
            end
            tick();
            rel++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_missing: got %0d strobes left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_live_bpm();
        ev_t got, e;
        int rel;
        for (int k = 0; k < STEPS; k++) write_pat(k, 16 + k);
        for (int k = 0; k <= 8; k++) begin
`ifdef STEP_SCHEDULER_LIVE_BPM_EN
            exp_q.push_back(mk((k <= 4) ? 1 + 50 * k : 201 + 100 * (k - 4), k));
`else
            exp_q.push_back(mk(1 + 50 * k, k));
`endif
        end
        start(120, 1);
        rel = 1;
        while (exp_q.size() > 0 && rel < 1100) begin
            if (bus.StepStrobe) begin
                got = {32'(rel), bus.Step, bus.Voice, bus.Trigger};
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL live_strobe: got cyc=%0d step=%0d voice=%0d, want cyc=%0d step=%0d voice=%0d",
                             got.cyc, got.step, got.voice, e.cyc, e.step, e.voice);
                end
                if (bus.Step == 4'd3) bus.BPM = 10'd60;
            end
            tick();
            rel++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL live_timeout: got %0d strobes left, want 0", exp_q.size());
            exp_q.delete();
        end
        stop();
    endtask

    initial begin
        bus.Start   = 1'b0;
        bus.Stop    = 1'b0;
        bus.BPM     = 10'd0;
        bus.Loops   = 7'd0;
        bus.PatWe   = 1'b0;
        bus.PatAddr = '0;
        bus.PatData = '0;
        for (int k = 0; k < STEPS; k++) pat[k] = 10'd0;
        test_reset();
        test_basic();
        test_nondiv();
        test_clamp();
        test_infinite_restart_stop();
        test_reset_mid_play();
        test_live_bpm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/step_scheduler.md
# step_scheduler

Playback sequencer between `input_interface` and `audio_interface`. Holds a STEPS-entry pattern of voice-select words and walks it at the commanded tempo for the commanded number of loops. At each step it emits a step strobe plus, for non-empty steps, a one-cycle voice trigger. Tempo uses an exact phase accumulator, so no divider is needed and long-run timing is exact for any BPM.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency; LIMIT = 60*CLK_HZ must be < 2^32 − 1024
- `STEPS`, 16, pattern length (power of two, ≥2)
- `VOICES`, 10, width of a voice-select word
- `CLOCK_50`  in  1  system clock; all logic on rising edge
- `nReset`  in  1  synchronous, active-low reset
- `Start`  in  1  one-cycle start/restart request
- `Stop`  in  1  one-cycle abort request
- `BPM`  in  10  tempo, beats (steps) per minute
- `Loops`  in  7  number of pattern passes; 0 = loop until Stop
- `PatWe`  in  1  pattern write enable
- `PatAddr`  in  log2(STEPS)  pattern write address
- `PatData`  in  VOICES  pattern write data; all-zero = rest
- `Busy`  out  1  high while playing
- `Step`  out  log2(STEPS)  index of the current step
- `StepStrobe`  out  1  one-cycle pulse at every step
- `Trigger`  out  1  one-cycle pulse at steps whose entry is non-zero
- `Voice`  out  VOICES  pattern entry of the current step, held until the next step
- `LoopCount`  out  7  completed passes since Start (wraps mod 128 when Loops=0)
- `Done`  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, PLAY.
  - IDLE → PLAY on Start.
  - PLAY → IDLE on Stop, or after the final step of the final pass.
- Start (from either state):
  - latch BPM_l = clamp(BPM, 30, 300) and Loops_l = Loops
  - clear acc (32 bits) and LoopCount
  - arm step 0
  - Start in PLAY restarts from step 0, pass 0.
- PLAY, every cycle after step 0 is issued:
  - sum = acc + BPM_l
  - if sum ≥ LIMIT: acc ← sum − LIMIT and take a step boundary; else acc ← sum.
- Step boundary:
  - if Step ≠ STEPS−1: Step+1.
  - else (wrap): LoopCount+1. If Loops_l ≠ 0 and LoopCount+1 = Loops_l: go IDLE and pulse Done, with no strobe. Otherwise Step ← 0.
- Each issued step sets StepStrobe=1, Voice=pattern[Step], and Trigger=1 iff that entry is non-zero.
- Stop: go IDLE next cycle, no Done, Step/Voice hold their values, Busy=0. Stop and Start in the same cycle: Stop wins.
- Pattern writes are accepted in any state. A write to the current step does not alter Voice until that step is next issued.
- Reset: state IDLE; all outputs 0; pattern cleared to zero; acc=0; BPM_l=30; Loops_l=0.

## Timing
- Start sampled in cycle N → Busy, StepStrobe, and step 0 are registered outputs in cycle N+1.
- Step boundary decided in cycle M → the new Step, Voice, StepStrobe and Trigger appear in cycle M+1.
- Strobe spacing is LIMIT/BPM_l cycles when that divides exactly. Otherwise spacing alternates between floor and ceil, and the error never accumulates.
- BPM=120 at 50 MHz gives exactly 25_000_000 cycles per step.
- Done and the Busy fall occur in the cycle where the next strobe would have appeared.
- Outputs are glitch-free registers; no combinational path from input to output.

## Configuration
- `STEP_SCHEDULER_LIVE_BPM_EN`
  - Defined: BPM is re-sampled and re-clamped into BPM_l at every step boundary, so a tempo change takes effect from the next step interval. acc is not cleared.
  - Undefined: BPM is latched only at Start; changes during PLAY are ignored.

## Test plan
All scenarios use CLK_HZ=100 (LIMIT=6000) and STEPS=16.
- Basic: pattern[k]=k (so step 0 is a rest), BPM=120, Loops=1, Start at cycle 0.
  - Strobes at cycles 1, 51, 101, …, 751.
  - Trigger absent at step 0, present on steps 1–15 with Voice=k.
  - Done and Busy fall at cycle 801; LoopCount=1.
- Non-divisible tempo: BPM=70.
  - Strobe spacing is 85 or 86 cycles.
  - The 70th strobe after step 0 lands exactly 6000 cycles after the step-0 strobe.
- Clamping:
  - BPM=0 → spacing 200 cycles (clamped to 30).
  - BPM=1000 → spacing 20 cycles (clamped to 300).
- Infinite / restart / stop:
  - Loops=0: playback runs past pass 128 with LoopCount wrapping to 0.
  - Start mid-pass: step 0 one cycle later, LoopCount=0.
  - Stop and Start in the same cycle: IDLE, no Done.
- Reset mid-PLAY: nReset low for one cycle at step 7.
  - Next cycle all outputs are 0 and the pattern reads all zero.
  - A subsequent Start yields no Trigger at any step.
- Live BPM, with the macro both defined and undefined: change BPM 120→60 at step 3.
  - Defined: spacing becomes 100 cycles from step 4 on.
  - Undefined: spacing stays 50.
